// File: rtl/insdecode_pkg.sv
// insdecode_pkg: shared definitions for the instruction decode stage.
//   - op_e     : opcode encoding, including the thread-control opcodes
//   - op_writes / op_uses_rs1 / op_uses_rs2 : per-opcode operand usage
//   - sext16   : 16-to-32-bit sign extension
//   - id_ex_t  : contents of the ID/EX pipeline register
//   - NUM_TRD / NUM_REG : thread count and registers per thread
package insdecode_pkg;

  localparam int NUM_TRD = 8;
  localparam int NUM_REG = 32;
  localparam int TRD_W   = $clog2(NUM_TRD);
  localparam int REG_W   = $clog2(NUM_REG);
  localparam int SB_W    = NUM_TRD * NUM_REG;

  typedef enum logic [5:0] {
    OP_NOP   = 6'h00,
    OP_ADD   = 6'h01,
    OP_SUB   = 6'h02,
    OP_AND   = 6'h03,
    OP_OR    = 6'h04,
    OP_ADDI  = 6'h05,
    OP_LD    = 6'h06,
    OP_ST    = 6'h07,
    OP_BEQ   = 6'h08,
    OP_TKILL = 6'h10,
    OP_TSLP  = 6'h11,
    OP_TWAKE = 6'h12,
    OP_TINIT = 6'h13
  } op_e;

  // Opcodes that produce a register result. Unlisted (illegal) opcodes
  // fall into the defaults and therefore behave as NOPs.
  function automatic logic op_writes(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LD: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  function automatic logic op_uses_rs1(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LD, OP_ST, OP_BEQ: return 1'b1;
      default:                                                      return 1'b0;
    endcase
  endfunction

  function automatic logic op_uses_rs2(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ST, OP_BEQ: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  typedef struct packed {
    logic             vld;
    logic [TRD_W-1:0] trd;
    logic [31:0]      pc;
    logic [5:0]       op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [31:0]      imm;
    logic             wr;
    logic             kill;
    logic             slp;
    logic             wake;
    logic             init;
    logic [TRD_W-1:0] obj_trd;
    logic [31:0]      init_pc;
  } id_ex_t;

endpackage

// File: rtl/insdecode_scoreboard.sv
// insdecode_scoreboard: per-thread pending-write bits (NUM_TRD x NUM_REG).
// Ports:
//   clk, rst                        clock, async active-high reset
//   i_set_en/i_set_trd/i_set_reg    mark a register pending (issue of a writer)
//   i_clr_en/i_clr_trd/i_clr_reg    retire a pending register (writeback)
//   i_rd_trd                        thread for all three lookups
//   i_rs1 / i_rs2 / i_waw           registers to look up
//   o_pend_rs1/o_pend_rs2/o_pend_waw pending status of those registers
// Config macro INSDECODE_WB_BYPASS_EN: lookups see a same-cycle writeback
// clear, letting a dependent instruction issue in the writeback cycle.
module insdecode_scoreboard
  import insdecode_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_set_en,
  input  logic [TRD_W-1:0] i_set_trd,
  input  logic [REG_W-1:0] i_set_reg,
  input  logic             i_clr_en,
  input  logic [TRD_W-1:0] i_clr_trd,
  input  logic [REG_W-1:0] i_clr_reg,
  input  logic [TRD_W-1:0] i_rd_trd,
  input  logic [REG_W-1:0] i_rs1,
  input  logic [REG_W-1:0] i_rs2,
  input  logic [REG_W-1:0] i_waw,
  output logic             o_pend_rs1,
  output logic             o_pend_rs2,
  output logic             o_pend_waw
);

  logic [SB_W-1:0] r_sb;
  logic [SB_W-1:0] w_view;

  logic [TRD_W+REG_W-1:0] w_set_idx;
  logic [TRD_W+REG_W-1:0] w_clr_idx;

  assign w_set_idx = {i_set_trd, i_set_reg};
  assign w_clr_idx = {i_clr_trd, i_clr_reg};

  // NOTE: sequential state uses non-blocking assignments; the later set
  // overrides the earlier clear, so a same-bit collision leaves it pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sb <= '0;
    end else begin
      if (i_clr_en)
        r_sb[w_clr_idx] <= 1'b0;
      if (i_set_en && (i_set_reg != '0))
        r_sb[w_set_idx] <= 1'b1;
    end
  end

  // NOTE: every combinational variable gets a default first so no latch forms.
  always_comb begin
    w_view = r_sb;
`ifdef INSDECODE_WB_BYPASS_EN
    if (i_clr_en)
      w_view[w_clr_idx] = 1'b0;
`endif
  end

  // r0 is never pending.
  assign o_pend_rs1 = (i_rs1 != '0) && w_view[{i_rd_trd, i_rs1}];
  assign o_pend_rs2 = (i_rs2 != '0) && w_view[{i_rd_trd, i_rs2}];
  assign o_pend_waw = (i_waw != '0) && w_view[{i_rd_trd, i_waw}];

endmodule

// File: rtl/insdecode.sv
// insdecode: instruction decode stage of the barrel-threaded pipeline.
// Registers the fetched word into a one-entry ID slot, decodes it, checks
// the per-thread scoreboard for RAW/WAW hazards and issues into ID/EX.
// Ports:
//   clk, rst                          clock, async active-high reset
//   if_vld, i_data, if_trd, if_pc     fetched word, its thread and PC
//   flushID, flushEX                  kill ID slot / ID/EX contents
//   stall_ex                          EX backpressure, holds ID/EX
//   wb_en, wb_trd, wb_rd              register writeback retire
//   stall                             fetch must re-present its word
//   ex_*                              ID/EX register fields
//   kill, slp, wake, init_trd         one-cycle thread-control pulses
//   act_trd, obj_trd, init_pc         thread-control operands
// Config macro INSDECODE_WB_BYPASS_EN: see insdecode_scoreboard.
module insdecode
  import insdecode_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             if_vld,
  input  logic [31:0]      i_data,
  input  logic [TRD_W-1:0] if_trd,
  input  logic [31:0]      if_pc,
  input  logic             flushID,
  input  logic             flushEX,
  input  logic             stall_ex,
  input  logic             wb_en,
  input  logic [TRD_W-1:0] wb_trd,
  input  logic [REG_W-1:0] wb_rd,
  output logic             stall,
  output logic             ex_vld,
  output logic [TRD_W-1:0] ex_trd,
  output logic [31:0]      ex_pc,
  output logic [5:0]       ex_op,
  output logic [REG_W-1:0] ex_rd,
  output logic [REG_W-1:0] ex_rs1,
  output logic [REG_W-1:0] ex_rs2,
  output logic [31:0]      ex_imm,
  output logic             ex_wr,
  output logic             kill,
  output logic             slp,
  output logic             wake,
  output logic             init_trd,
  output logic [TRD_W-1:0] act_trd,
  output logic [TRD_W-1:0] obj_trd,
  output logic [31:0]      init_pc
);

  // ID slot
  logic             r_id_vld;
  logic [31:0]      r_id_data;
  logic [TRD_W-1:0] r_id_trd;
  logic [31:0]      r_id_pc;

  // Decode of the slot
  logic [5:0]       w_op;
  logic [REG_W-1:0] w_rd;
  logic [REG_W-1:0] w_rs1;
  logic [REG_W-1:0] w_rs2;
  logic [31:0]      w_imm;
  logic             w_wr;
  logic             w_pend_rs1;
  logic             w_pend_rs2;
  logic             w_pend_waw;
  logic             w_haz;
  logic             w_issue;
  id_ex_t           w_ex_nxt;
  id_ex_t           r_ex;

  assign w_op  = r_id_data[31:26];
  assign w_rd  = r_id_data[25:21];
  assign w_rs1 = r_id_data[20:16];
  assign w_rs2 = r_id_data[15:11];
  assign w_imm = sext16(r_id_data[15:0]);
  assign w_wr  = op_writes(w_op) && (w_rd != '0);

  insdecode_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_set_en   (w_issue & w_wr),
    .i_set_trd  (r_id_trd),
    .i_set_reg  (w_rd),
    .i_clr_en   (wb_en),
    .i_clr_trd  (wb_trd),
    .i_clr_reg  (wb_rd),
    .i_rd_trd   (r_id_trd),
    .i_rs1      (w_rs1),
    .i_rs2      (w_rs2),
    .i_waw      (w_rd),
    .o_pend_rs1 (w_pend_rs1),
    .o_pend_rs2 (w_pend_rs2),
    .o_pend_waw (w_pend_waw)
  );

  assign w_haz = r_id_vld & ((op_uses_rs1(w_op) & w_pend_rs1) |
                             (op_uses_rs2(w_op) & w_pend_rs2) |
                             (w_wr & w_pend_waw));

  assign w_issue = r_id_vld & ~w_haz & ~stall_ex & ~flushID;
  assign stall   = r_id_vld & ~flushID & (w_haz | stall_ex);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_vld  <= 1'b0;
      r_id_data <= '0;
      r_id_trd  <= '0;
      r_id_pc   <= '0;
    end else if (if_vld && !stall) begin
      r_id_vld  <= 1'b1;
      r_id_data <= i_data;
      r_id_trd  <= if_trd;
      r_id_pc   <= if_pc;
    end else if (!stall) begin
      r_id_vld  <= 1'b0;
    end
  end

  always_comb begin
    w_ex_nxt         = '0;
    w_ex_nxt.vld     = 1'b1;
    w_ex_nxt.trd     = r_id_trd;
    w_ex_nxt.pc      = r_id_pc;
    w_ex_nxt.op      = w_op;
    w_ex_nxt.rd      = w_rd;
    w_ex_nxt.rs1     = w_rs1;
    w_ex_nxt.rs2     = w_rs2;
    w_ex_nxt.imm     = w_imm;
    w_ex_nxt.wr      = w_wr;
    w_ex_nxt.kill    = (w_op == OP_TKILL);
    w_ex_nxt.slp     = (w_op == OP_TSLP);
    w_ex_nxt.wake    = (w_op == OP_TWAKE);
    w_ex_nxt.init    = (w_op == OP_TINIT);
    w_ex_nxt.obj_trd = r_id_data[18:16];
    w_ex_nxt.init_pc = r_id_pc + {w_imm[29:0], 2'b00};
  end

  // Pulses drop after one cycle even while stall_ex holds the rest of ID/EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex <= '0;
    end else if (flushEX) begin
      r_ex.vld  <= 1'b0;
      r_ex.kill <= 1'b0;
      r_ex.slp  <= 1'b0;
      r_ex.wake <= 1'b0;
      r_ex.init <= 1'b0;
    end else if (w_issue) begin
      r_ex <= w_ex_nxt;
    end else begin
      r_ex.kill <= 1'b0;
      r_ex.slp  <= 1'b0;
      r_ex.wake <= 1'b0;
      r_ex.init <= 1'b0;
      if (!stall_ex)
        r_ex.vld <= 1'b0;
    end
  end

  assign ex_vld   = r_ex.vld;
  assign ex_trd   = r_ex.trd;
  assign ex_pc    = r_ex.pc;
  assign ex_op    = r_ex.op;
  assign ex_rd    = r_ex.rd;
  assign ex_rs1   = r_ex.rs1;
  assign ex_rs2   = r_ex.rs2;
  assign ex_imm   = r_ex.imm;
  assign ex_wr    = r_ex.wr;
  assign kill     = r_ex.kill;
  assign slp      = r_ex.slp;
  assign wake     = r_ex.wake;
  assign init_trd = r_ex.init;
  assign act_trd  = r_ex.trd;
  assign obj_trd  = r_ex.obj_trd;
  assign init_pc  = r_ex.init_pc;

endmodule

// File: doc/insdecode.md
# insdecode

Instruction decode stage of the barrel-threaded pipeline: it sits directly downstream of instruction fetch. It registers the fetched word with its thread and PC into a one-entry ID slot. It decodes fields and checks a per-thread register scoreboard for hazards, then issues into the ID/EX register. It also produces the thread-control commands (kill, sleep, wake, init) that fetch consumes, and the `stall` that freezes fetch.

## Interface
- `NUM_TRD`, 8, hardware threads; thread id width is 3.
- `NUM_REG`, 32, architectural registers per thread; r0 is never tracked.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `if_vld` in 1: fetch word valid this cycle (fetch `i_rd` and no `i_miss`).
- `i_data` in 32: fetched instruction.
- `if_trd` in 3: thread of the fetched word.
- `if_pc` in 32: PC of the fetched word.
- `flushID` in 1: kill the ID-slot instruction.
- `flushEX` in 1: kill the ID/EX register contents.
- `stall_ex` in 1: EX cannot accept; hold ID/EX.
- `wb_en` in 1: writeback retires a register write.
- `wb_trd` in 3: thread of the writeback.
- `wb_rd` in 5: register of the writeback.
- `stall` out 1: fetch must hold and re-present the same word.
- `ex_vld` out 1: ID/EX valid.
- `ex_trd` out 3: thread of the instruction in ID/EX.
- `ex_pc` out 32: PC of the instruction in ID/EX.
- `ex_op` out 6: opcode.
- `ex_rd` out 5: destination register field.
- `ex_rs1` out 5: first source register field.
- `ex_rs2` out 5: second source register field.
- `ex_imm` out 32: sign-extended immediate.
- `ex_wr` out 1: instruction writes `ex_rd`.
- `kill` out 1: thread-control pulse, valid with `ex_vld`.
- `slp` out 1: thread-control pulse, valid with `ex_vld`.
- `wake` out 1: thread-control pulse, valid with `ex_vld`.
- `init_trd` out 1: thread-control pulse, valid with `ex_vld`.
- `act_trd` out 3: commanding thread; equals `ex_trd`.
- `obj_trd` out 3: target thread; equals `i_data[18:16]` of the issued word.
- `init_pc` out 32: start PC for a new thread; equals `ex_pc + (sext(imm16) << 2)`.

## Operation
- **Instruction format:**
  - op = [31:26], rd = [25:21], rs1 = [20:16], rs2 = [15:11], imm16 = [15:0].
  - `ex_wr` = op is in the write class and rd != 0.
- **ID slot (`id_vld`):**
  - Loads when `if_vld & !stall`.
  - Otherwise retains its contents while `stall`, else clears.
- **Hazard:** `haz` = `id_vld` and the pending bit `sb[trd][r]` is set for any of:
  - rs1, when used;
  - rs2, when used;
  - rd, when writing (WAW).
- **Issue:** `issue = id_vld & !haz & !stall_ex & !flushID`.
- **Stall:** `stall = id_vld & !flushID & (haz | stall_ex)`.
- **ID/EX register:**
  - On `issue`, loads all `ex_*` fields and the thread-control pulses.
  - Else if `!stall_ex`, clears `ex_vld` and all pulses.
  - `flushEX` clears `ex_vld` and all pulses, with priority over both.
- **Scoreboard (256 bits):**
  - Set on `issue & ex_wr` at [trd][rd].
  - Cleared on `wb_en` at [wb_trd][wb_rd].
  - Same bit set and cleared in the same cycle: set wins.
- **Flushes:**
  - `flushID` drops the slot and never touches the scoreboard.
  - A flushed ID/EX writer keeps its bit; EX/WB signals `wb_en` for it regardless.
- **Illegal opcode:** decodes as a NOP (`ex_wr` = 0, no pulses) but still issues.
- **Reset:** all outputs 0, `id_vld` = 0, scoreboard all clear.
- **Reset mid-stall:** discards the held instruction; fetch replays from its own PC state.

## Timing
- Fetched word at edge N → ID slot → `ex_vld` at edge N+1 at the earliest (1-cycle ID latency, no hazard).
- `stall` is combinational from the ID slot, `stall_ex`, `flushID` and the scoreboard.
- Thread-control pulses last exactly one cycle per issued instruction, even under a subsequent `stall_ex`.
- RAW on a just-issued writer:
  - A dependent instruction in the next cycle stalls until its `wb_en`.
  - Minimum bubble = cycles to writeback, +1 without bypass (see Configuration).

## Configuration
- **`INSDECODE_WB_BYPASS_EN`:**
  - Defined: the hazard check uses `sb & ~wb_clear_mask` in the same cycle, so a dependent instruction issues in the writeback cycle.
  - Undefined: the hazard check uses registered `sb` only, so issue occurs one cycle after `wb_en`.

## Structure
- **Package `insdecode_pkg`:**
  - opcode enum `op_e`, including OP_TKILL, OP_TSLP, OP_TWAKE and OP_TINIT.
  - write-class and source-use lookup functions.
  - the `id_ex_t` struct.
  - constants `NUM_TRD` and `NUM_REG`.
- **Sub-module `scoreboard`:**
  - Holds the 256-bit pending array.
  - Ports: set, clear, two read ports plus a WAW port, and the bypass macro.

## Test plan
- **Reset:** `rst` = 1 mid-stall → all `ex_*` = 0, `stall` = 0; after release `sb` = 0.
- **Plain issue:** ADD r3 on thread 2 at `if_pc` 0x100 → next edge `ex_vld` = 1, `ex_trd` = 2, `ex_pc` = 0x100, `ex_rd` = 3, `ex_wr` = 1, `sb[2][3]` = 1.
- **RAW across threads:**
  - Thread 2 reads r3 → `stall` = 1 until `wb_en`, `wb_trd` = 2, `wb_rd` = 3.
  - With the bypass macro it issues that cycle; without it, one cycle later.
  - Thread 5 reading r3 issues with no stall.
- **Thread control:**
  - OP_TINIT from thread 1, `i_data[18:16]` = 4, imm16 = 0xFFFF, pc 0x200 → `init_trd` = 1 for one cycle, `act_trd` = 1, `obj_trd` = 4, `init_pc` = 0x1FC.
- **Flush and backpressure:**
  - `flushID` while held by a hazard → slot dropped, `stall` = 0, `sb` unchanged.
  - `stall_ex` for 3 cycles → `ex_*` stable and `stall` = 1 throughout.
- **Set/clear collision:** issue of writer r7 on thread 0 with `wb_en` r7 thread 0 in the same cycle → `sb[0][7]` = 1.
